// File: rtl/instruction_decode_stage.sv
// MIPS decode stage: 32x32 register file with WB bypass, control decoder, sign extender, ID/EX latch.
// One cycle of latency; i_stall holds the latch, i_flush loads a bubble. Optional debug read port: ID_REGFILE_DEBUG_EN.
module instruction_decode_stage #(
  parameter int len      = 32,
  parameter int NB_REG   = 5,
  parameter int NB_ALUOP = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [len-1:0]      i_instruccion,
  input  logic [len-1:0]      i_adder,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_RegWrite,
  input  logic [NB_REG-1:0]   i_write_reg,
  input  logic [len-1:0]      i_write_data,
  output logic [len-1:0]      o_read_data1,
  output logic [len-1:0]      o_read_data2,
  output logic [len-1:0]      o_sign_ext,
  output logic [NB_REG-1:0]   o_rs,
  output logic [NB_REG-1:0]   o_rt,
  output logic [NB_REG-1:0]   o_rd,
  output logic [len-1:0]      o_adder,
  output logic                o_RegDst,
  output logic                o_ALUSrc,
  output logic                o_MemRead,
  output logic                o_MemWrite,
  output logic                o_MemtoReg,
  output logic                o_RegWrite,
  output logic                o_Branch,
  output logic [NB_ALUOP-1:0] o_ALUOp
`ifdef ID_REGFILE_DEBUG_EN
  ,
  input  logic [NB_REG-1:0]   i_dbg_addr,
  output logic [len-1:0]      o_dbg_data
`endif
);

  localparam int NUM_REGS = 2 ** NB_REG;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef struct packed {
    logic [len-1:0]      read_data1;
    logic [len-1:0]      read_data2;
    logic [len-1:0]      sign_ext;
    logic [len-1:0]      adder;
    logic [NB_REG-1:0]   rs;
    logic [NB_REG-1:0]   rt;
    logic [NB_REG-1:0]   rd;
    logic                reg_dst;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                reg_write;
    logic                branch;
    logic [NB_ALUOP-1:0] alu_op;
  } id_ex_t;

  logic [NUM_REGS-1:0][len-1:0] regs_q, regs_d;
  id_ex_t                       id_ex_q, id_ex_d;
  id_ex_t                       id_ex_load;

  logic [5:0]        opcode;
  logic [NB_REG-1:0] rs, rt, rd;
  logic              wb_en;

  assign opcode = i_instruccion[31:26];
  assign rs     = i_instruccion[25:21];
  assign rt     = i_instruccion[20:16];
  assign rd     = i_instruccion[15:11];
  assign wb_en  = i_RegWrite && (i_write_reg != '0);

  // Fresh ID/EX contents; a WB write landing this cycle beats the stale register value.
  always_comb begin
    id_ex_load            = '0;
    id_ex_load.rs         = rs;
    id_ex_load.rt         = rt;
    id_ex_load.rd         = rd;
    id_ex_load.adder      = i_adder;
    id_ex_load.sign_ext   = {{(len-16){i_instruccion[15]}}, i_instruccion[15:0]};
    if (rs == '0)                         id_ex_load.read_data1 = '0;
    else if (wb_en && i_write_reg == rs)  id_ex_load.read_data1 = i_write_data;
    else                                  id_ex_load.read_data1 = regs_q[rs];
    if (rt == '0)                         id_ex_load.read_data2 = '0;
    else if (wb_en && i_write_reg == rt)  id_ex_load.read_data2 = i_write_data;
    else                                  id_ex_load.read_data2 = regs_q[rt];

    case (opcode)
      OP_RTYPE: begin
        id_ex_load.reg_dst   = 1'b1;
        id_ex_load.reg_write = 1'b1;
        id_ex_load.alu_op    = NB_ALUOP'(2'b10);
      end
      OP_LW: begin
        id_ex_load.alu_src    = 1'b1;
        id_ex_load.mem_read   = 1'b1;
        id_ex_load.mem_to_reg = 1'b1;
        id_ex_load.reg_write  = 1'b1;
      end
      OP_SW: begin
        id_ex_load.alu_src   = 1'b1;
        id_ex_load.mem_write = 1'b1;
      end
      OP_BEQ: begin
        id_ex_load.branch = 1'b1;
        id_ex_load.alu_op = NB_ALUOP'(2'b01);
      end
      OP_ADDI: begin
        id_ex_load.alu_src   = 1'b1;
        id_ex_load.reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Writeback is independent of stall/flush; only reset blocks it.
  always_comb begin
    regs_d = regs_q;
    if (wb_en) regs_d[i_write_reg] = i_write_data;

    id_ex_d = id_ex_q;
    if (i_flush)       id_ex_d = '0;
    else if (!i_stall) id_ex_d = id_ex_load;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regs_q  <= '0;
      id_ex_q <= '0;
    end else begin
      regs_q  <= regs_d;
      id_ex_q <= id_ex_d;
    end
  end

  assign o_read_data1 = id_ex_q.read_data1;
  assign o_read_data2 = id_ex_q.read_data2;
  assign o_sign_ext   = id_ex_q.sign_ext;
  assign o_rs         = id_ex_q.rs;
  assign o_rt         = id_ex_q.rt;
  assign o_rd         = id_ex_q.rd;
  assign o_adder      = id_ex_q.adder;
  assign o_RegDst     = id_ex_q.reg_dst;
  assign o_ALUSrc     = id_ex_q.alu_src;
  assign o_MemRead    = id_ex_q.mem_read;
  assign o_MemWrite   = id_ex_q.mem_write;
  assign o_MemtoReg   = id_ex_q.mem_to_reg;
  assign o_RegWrite   = id_ex_q.reg_write;
  assign o_Branch     = id_ex_q.branch;
  assign o_ALUOp      = id_ex_q.alu_op;

`ifdef ID_REGFILE_DEBUG_EN
  assign o_dbg_data = (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Randomized bench for instruction_decode_stage against a register-array reference model.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, adder, wdata;
  logic        stall, flush, we;
  logic [4:0]  wreg;
  logic [31:0] o_rd1, o_rd2, o_sext, o_adder;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg, o_regwrite, o_branch;
  logic [1:0]  o_aluop;
`ifdef ID_REGFILE_DEBUG_EN
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_instruccion(instr), .i_adder(adder),
    .i_stall(stall), .i_flush(flush), .i_RegWrite(we), .i_write_reg(wreg),
    .i_write_data(wdata),
    .o_read_data1(o_rd1), .o_read_data2(o_rd2), .o_sign_ext(o_sext),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_adder(o_adder),
    .o_RegDst(o_regdst), .o_ALUSrc(o_alusrc), .o_MemRead(o_memread),
    .o_MemWrite(o_memwrite), .o_MemtoReg(o_memtoreg), .o_RegWrite(o_regwrite),
    .o_Branch(o_branch), .o_ALUOp(o_aluop)
`ifdef ID_REGFILE_DEBUG_EN
    , .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural registers plus the expected latch view.
  logic [31:0] mregs [32];
  logic [31:0] e_rd1, e_rd2, e_sext, e_adder;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [8:0]  e_ctl;  // {RegDst,ALUSrc,MemRead,MemWrite,MemtoReg,RegWrite,Branch,ALUOp[1:0]}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] ctl_table(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b1_0_0_0_0_1_0_10;
      6'h23:   return 9'b0_1_1_0_1_1_0_00;
      6'h2B:   return 9'b0_1_0_1_0_0_0_00;
      6'h04:   return 9'b0_0_0_0_0_0_1_01;
      6'h08:   return 9'b0_1_0_0_0_1_0_00;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] reg_seen(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (we && wreg == a) return wdata;
    return mregs[a];
  endfunction

  task automatic check_outputs();
    chk("read_data1", o_rd1, e_rd1);
    chk("read_data2", o_rd2, e_rd2);
    chk("sign_ext", o_sext, e_sext);
    chk("adder", o_adder, e_adder);
    chk("rs", {27'h0, o_rs}, {27'h0, e_rs});
    chk("rt", {27'h0, o_rt}, {27'h0, e_rt});
    chk("rd", {27'h0, o_rd}, {27'h0, e_rd});
    chk("control", {23'h0, o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg,
                    o_regwrite, o_branch, o_aluop}, {23'h0, e_ctl});
  endtask

  // Apply current inputs across one rising edge, advance the model, then compare.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'h0;
      {e_rd1, e_rd2, e_sext, e_adder, e_rs, e_rt, e_rd, e_ctl} = '0;
    end else begin
      if (flush) begin
        {e_rd1, e_rd2, e_sext, e_adder, e_rs, e_rt, e_rd, e_ctl} = '0;
      end else if (!stall) begin
        e_rs    = instr[25:21];
        e_rt    = instr[20:16];
        e_rd    = instr[15:11];
        e_rd1   = reg_seen(e_rs);
        e_rd2   = reg_seen(e_rt);
        e_sext  = {{16{instr[15]}}, instr[15:0]};
        e_adder = adder;
        e_ctl   = ctl_table(instr[31:26]);
      end
      if (we && wreg != 0) mregs[wreg] = wdata;
    end
    #1;
    check_outputs();
`ifdef ID_REGFILE_DEBUG_EN
    chk("dbg_data", dbg_data, mregs[dbg_addr]);
`endif
  endtask

  task automatic idle_inputs();
    rst = 0; stall = 0; flush = 0; we = 0; wreg = 0; wdata = 0;
    instr = 32'hFC00_0000; adder = 0;
  endtask

  initial begin
    foreach (mregs[i]) mregs[i] = 32'h0;
    {e_rd1, e_rd2, e_sext, e_adder, e_rs, e_rt, e_rd, e_ctl} = '0;
    idle_inputs();
`ifdef ID_REGFILE_DEBUG_EN
    dbg_addr = 0;
`endif

    // Reset with garbage on every input, including a WB write.
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      instr = $urandom; adder = $urandom; stall = 1'($urandom); flush = 1'($urandom);
      we = 1; wreg = 5'd7; wdata = $urandom;
      step();
    end
    chk("rst_rd1", o_rd1, 32'h0);
    chk("rst_regwrite", {31'h0, o_regwrite}, 32'h0);
    idle_inputs();

    // Every register reads zero after reset.
    for (int r = 0; r < 32; r++) begin
      instr = {6'h00, 5'(r), 5'(r), 16'h0};
      step();
      chk("reset_reg_zero", o_rd1, 32'h0);
    end

    // WB write, then read through an R-type.
    we = 1; wreg = 5; wdata = 32'hDEADBEEF; step();
    idle_inputs();
    instr = 32'h00A62020; adder = 32'h104; step();
    chk("add_rd1", o_rd1, 32'hDEADBEEF);
    chk("add_fields", {17'h0, o_rs, o_rt, o_rd}, {17'h0, 5'd5, 5'd6, 5'd4});
    chk("add_ctl", {23'h0, o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg,
                    o_regwrite, o_branch, o_aluop}, {23'h0, 9'b1_0_0_0_0_1_0_10});

    // Same-cycle bypass into a load.
    instr = 32'h8D09FFFC; we = 1; wreg = 8; wdata = 32'h12345678; step();
    chk("byp_rd1", o_rd1, 32'h12345678);
    chk("byp_sext", o_sext, 32'hFFFFFFFC);
    idle_inputs();

    // Write to $0 is dropped, even when bypass would match.
    instr = 32'h00000000; we = 1; wreg = 0; wdata = 32'hFFFFFFFF; step();
    chk("zero_bypass", o_rd1, 32'h0);
    idle_inputs();
    instr = 32'h00000000; step();
    chk("zero_reg", o_rd2, 32'h0);

    // Stall holds the latch; WB writes still land.
    instr = 32'hAD090004; step();
    for (int i = 0; i < 3; i++) begin
      stall = 1; instr = $urandom; adder = $urandom;
      we = 1; wreg = 5'(10 + i); wdata = $urandom;
      step();
      chk("stall_memwrite", {31'h0, o_memwrite}, 32'h1);
      chk("stall_sext", o_sext, 32'h4);
    end
    stall = 1; flush = 1; we = 0; instr = 32'h00A62020; step();
    chk("flush_rd1", o_rd1, 32'h0);
    chk("flush_ctl", {31'h0, o_regdst}, 32'h0);
    idle_inputs();

    // Unknown opcode: data fields pass, control zero.
    instr = 32'hFC000000; adder = 32'h40; step();
    chk("nop_adder", o_adder, 32'h40);
    chk("nop_ctl", {23'h0, o_regdst, o_alusrc, o_memread, o_memwrite, o_memtoreg,
                    o_regwrite, o_branch, o_aluop}, 32'h0);

`ifdef ID_REGFILE_DEBUG_EN
    we = 1; wreg = 31; wdata = 32'hA5A5A5A5; dbg_addr = 31; step();
    chk("dbg_r31", dbg_data, 32'hA5A5A5A5);
    idle_inputs();
`endif

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      logic [5:0] op;
      case ($urandom_range(0, 5))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B;
        3: op = 6'h04; 4: op = 6'h08; default: op = 6'($urandom);
      endcase
      instr = {op, 26'($urandom)};
      adder = $urandom;
      rst   = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      we    = 1'($urandom);
      wreg  = ($urandom_range(0, 3) == 0) ? instr[25:21] : 5'($urandom);
      wdata = $urandom;
`ifdef ID_REGFILE_DEBUG_EN
      dbg_addr = 5'($urandom);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
